mux_full_subtractor: RTL and testbench

- Registered full subtractor that computes D = A − B − Bin and a borrow-out.
- Each bit cell is built from 4:1 multiplexers, selected by {A,B}, with data inputs derived from the incoming borrow.
- The cells are chained as a ripple-borrow subtractor of parameterizable width. Results are registered on one clock.
- Used as a leaf arithmetic primitive. WIDTH=1 is the canonical single-bit full subtractor.

---
 rtl/mux_full_subtractor.sv | 56 +++++
 tb/tb_mux_full_subtractor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux_full_subtractor.sv
// Registered ripple-borrow subtractor: {b1,d} = a - b - b0, one cycle latency.
// Every bit cell is two 4:1 multiplexers selected by {a[i], b[i]}.
module mux_full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b0,
    input  logic             in_valid,
    output logic [WIDTH-1:0] d,
    output logic             b1,
    output logic             out_valid
);

    // din[sel] with sel = {Ai, Bi}; din[0] is the 00 leg.
    function automatic logic mux4(input logic [1:0] sel, input logic [3:0] din);
        return din[sel];
    endfunction

    logic [WIDTH:0]   borrow_p0;
    logic [WIDTH-1:0] diff_p0;
    logic [WIDTH-1:0] d_p1;
    logic             b1_p1;
    logic             vld_p1;

    assign borrow_p0[0] = b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign diff_p0[i]     = mux4({a[i], b[i]},
                                     {borrow_p0[i], ~borrow_p0[i], ~borrow_p0[i], borrow_p0[i]});
        assign borrow_p0[i+1] = mux4({a[i], b[i]},
                                     {borrow_p0[i], 1'b0, 1'b1, borrow_p0[i]});
    end

    // Stage p0 -> p1: capture on valid, hold otherwise; reset clears result too.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_p1   <= '0;
            b1_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                d_p1  <= diff_p0;
                b1_p1 <= borrow_p0[WIDTH];
            end
        end
    end

    assign d         = d_p1;
    assign b1        = b1_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_full_subtractor.sv
// Bench for mux_full_subtractor at WIDTH 1, 4 and 8 against arithmetic expectations.
module tb_mux_full_subtractor;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic       w1_a, w1_b, w1_bin, w1_vld, w1_d, w1_bo, w1_ov;
    logic [3:0] w4_a, w4_b, w4_d;
    logic       w4_bin, w4_vld, w4_bo, w4_ov;
    logic [7:0] w8_a, w8_b, w8_d;
    logic       w8_bin, w8_vld, w8_bo, w8_ov;

    mux_full_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(w1_a), .b(w1_b), .b0(w1_bin), .in_valid(w1_vld),
        .d(w1_d), .b1(w1_bo), .out_valid(w1_ov)
    );
    mux_full_subtractor #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .a(w4_a), .b(w4_b), .b0(w4_bin), .in_valid(w4_vld),
        .d(w4_d), .b1(w4_bo), .out_valid(w4_ov)
    );
    mux_full_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(w8_a), .b(w8_b), .b0(w8_bin), .in_valid(w8_vld),
        .d(w8_d), .b1(w8_bo), .out_valid(w8_ov)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        w1_vld = 1'b1; w1_a = 1'b1; w1_b = 1'b0; w1_bin = 1'b0;
        w4_vld = 1'b1; w4_a = 4'h1; w4_b = 4'h0; w4_bin = 1'b0;
        w8_vld = 1'b1; w8_a = 8'h01; w8_b = 8'h00; w8_bin = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({w1_d, w1_bo, w1_ov} !== 3'b000) begin
                errors++;
                $display("FAIL reset_w1 cycle %0d: d=%b b1=%b ov=%b, required 0 0 0", c, w1_d, w1_bo, w1_ov);
            end
            checks++;
            if ({w4_d, w4_bo, w4_ov} !== 6'b0) begin
                errors++;
                $display("FAIL reset_w4 cycle %0d: d=%h b1=%b ov=%b, required 0 0 0", c, w4_d, w4_bo, w4_ov);
            end
            checks++;
            if ({w8_d, w8_bo, w8_ov} !== 10'b0) begin
                errors++;
                $display("FAIL reset_w8 cycle %0d: d=%h b1=%b ov=%b, required 0 0 0", c, w8_d, w8_bo, w8_ov);
            end
        end
        rst = 1'b0;
        w1_vld = 1'b0; w4_vld = 1'b0; w8_vld = 1'b0;
    endtask

    task automatic test_truth_w1();
        logic [7:0] tt_d;
        logic [7:0] tt_b;
        logic [2:0] idx;
        tt_d = 8'b1001_0110;  // bit index = {A,B,Bin}
        tt_b = 8'b1000_1110;
        for (int k = 0; k < 8; k++) begin
            idx = 3'(k);
            {w1_a, w1_b, w1_bin} = idx;
            w1_vld = 1'b1;
            step();
            checks++;
            if ({w1_d, w1_bo, w1_ov} !== {tt_d[idx], tt_b[idx], 1'b1}) begin
                errors++;
                $display("FAIL truth_w1 abc=%b: d=%b b1=%b ov=%b, required %b %b 1",
                         idx, w1_d, w1_bo, w1_ov, tt_d[idx], tt_b[idx]);
            end
        end
        w1_vld = 1'b0;
    endtask

    task automatic test_hold_w1();
        w1_a = 1'b1; w1_b = 1'b0; w1_bin = 1'b0; w1_vld = 1'b1;
        step();
        checks++;
        if ({w1_d, w1_bo, w1_ov} !== 3'b101) begin
            errors++;
            $display("FAIL hold_capture: d=%b b1=%b ov=%b, required 1 0 1", w1_d, w1_bo, w1_ov);
        end
        w1_vld = 1'b0; w1_a = 1'b0; w1_b = 1'b1; w1_bin = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({w1_d, w1_bo, w1_ov} !== 3'b100) begin
                errors++;
                $display("FAIL hold_idle cycle %0d: d=%b b1=%b ov=%b, required 1 0 0", c, w1_d, w1_bo, w1_ov);
            end
        end
    endtask

    task automatic test_ripple_w4();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vc [3];
        logic [4:0] exp5;
        va = '{4'h0, 4'h9, 4'h3};
        vb = '{4'h0, 4'h3, 4'h9};
        vc = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            w4_a = va[k]; w4_b = vb[k]; w4_bin = vc[k]; w4_vld = 1'b1;
            exp5 = {1'b0, va[k]} - {1'b0, vb[k]} - 5'(vc[k]);
            step();
            checks++;
            if ({w4_bo, w4_d, w4_ov} !== {exp5, 1'b1}) begin
                errors++;
                $display("FAIL ripple_w4 a=%h b=%h b0=%b: b1=%b d=%h ov=%b, required b1=%b d=%h ov=1",
                         va[k], vb[k], vc[k], w4_bo, w4_d, w4_ov, exp5[4], exp5[3:0]);
            end
        end
        w4_vld = 1'b0;
    endtask

    task automatic test_reset_midstream();
        w4_a = 4'h5; w4_b = 4'h2; w4_bin = 1'b0; w4_vld = 1'b1;
        step();
        w4_a = 4'hA; w4_b = 4'h1; w4_bin = 1'b1; rst = 1'b1;
        step();
        checks++;
        if ({w4_bo, w4_d, w4_ov} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_clear: b1=%b d=%h ov=%b, required 0 0 0", w4_bo, w4_d, w4_ov);
        end
        rst = 1'b0;
        w4_a = 4'h2; w4_b = 4'h7; w4_bin = 1'b0;
        step();
        checks++;
        if ({w4_bo, w4_d, w4_ov} !== {1'b1, 4'hB, 1'b1}) begin
            errors++;
            $display("FAIL midreset_next: b1=%b d=%h ov=%b, required 1 b 1", w4_bo, w4_d, w4_ov);
        end
        w4_vld = 1'b0;
    endtask

    task automatic test_random_w8();
        logic [8:0] exp9;
        logic       v;
        exp9 = 9'h0;  // w8 has held its reset value since the last reset
        for (int k = 0; k < 1000; k++) begin
            v = 1'($urandom_range(0, 1));
            w8_a = 8'($urandom); w8_b = 8'($urandom); w8_bin = 1'($urandom);
            w8_vld = v;
            if (v) exp9 = {1'b0, w8_a} - {1'b0, w8_b} - 9'(w8_bin);
            step();
            checks++;
            if ({w8_bo, w8_d, w8_ov} !== {exp9, v}) begin
                errors++;
                $display("FAIL random_w8 #%0d: b1=%b d=%h ov=%b, required b1=%b d=%h ov=%b",
                         k, w8_bo, w8_d, w8_ov, exp9[8], exp9[7:0], v);
            end
        end
        w8_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        w1_a = 1'b0; w1_b = 1'b0; w1_bin = 1'b0; w1_vld = 1'b0;
        w4_a = 4'h0; w4_b = 4'h0; w4_bin = 1'b0; w4_vld = 1'b0;
        w8_a = 8'h0; w8_b = 8'h0; w8_bin = 1'b0; w8_vld = 1'b0;
        #2;
        test_reset();
        test_truth_w1();
        test_hold_w1();
        test_ripple_w4();
        test_reset_midstream();
        test_random_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
